// File: rtl/mem_bus_if_if.sv
// Bundle of the control-unit request/response signals and the external memory bus.
// The master modport is the bus-interface stage; slave is the control unit plus memory side.
interface mem_bus_if_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 16
);
  logic                  Req;
  logic                  ReqWrite;
  logic [ADDR_WIDTH-1:0] AddrIn;
  logic [DATA_WIDTH-1:0] WDataIn;
  logic                  Busy;
  logic                  Done;
  logic                  Err;
  logic [DATA_WIDTH-1:0] RData;
  logic                  RDataOE;
  logic [ADDR_WIDTH-1:0] MemAddr;
  logic [DATA_WIDTH-1:0] MemDataOut;
  logic                  MemDataOE;
  logic [DATA_WIDTH-1:0] MemDataIn;
  logic                  nME;
  logic                  nOE;
  logic                  RnW;
  logic                  nWait;

  modport master (
    input  Req, ReqWrite, AddrIn, WDataIn, MemDataIn, nWait,
    output Busy, Done, Err, RData, RDataOE, MemAddr, MemDataOut, MemDataOE, nME, nOE, RnW
  );

  modport slave (
    output Req, ReqWrite, AddrIn, WDataIn, MemDataIn, nWait,
    input  Busy, Done, Err, RData, RDataOE, MemAddr, MemDataOut, MemDataOE, nME, nOE, RnW
  );
endinterface

// File: rtl/mem_bus_if.sv
// Memory bus interface stage: one read/write cycle per accepted Req, nWait-stretched.
// Optional wait-state timeout abort enabled by defining MEM_TIMEOUT_EN.
module mem_bus_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 16,
  parameter int TIMEOUT    = 15
) (
  input  logic          Clock,
  input  logic          nReset,
  mem_bus_if_if.master  bus
);
  typedef enum logic [1:0] {IDLE, ADDR, ACCESS, DONE} state_t;

  state_t state;
  logic   isWrite;
  logic   timeoutHit;
  logic   accessEnd;

`ifdef MEM_TIMEOUT_EN
  localparam logic [7:0] WaitLast = 8'(TIMEOUT - 1);
  logic [7:0] waitCnt;
  // The cycle that would make the count reach TIMEOUT ends the access instead.
  assign timeoutHit = !bus.nWait && (waitCnt == WaitLast);
`else
  assign timeoutHit = 1'b0;
  assign bus.Err    = 1'b0;
`endif

  assign accessEnd = bus.nWait || timeoutHit;

  always_ff @(posedge Clock) begin
    if (!nReset) begin
      state          <= IDLE;
      isWrite        <= 1'b0;
      bus.nME        <= 1'b1;
      bus.nOE        <= 1'b1;
      bus.RnW        <= 1'b1;
      bus.MemDataOE  <= 1'b0;
      bus.MemAddr    <= '0;
      bus.MemDataOut <= '0;
      bus.RData      <= '0;
      bus.RDataOE    <= 1'b0;
      bus.Busy       <= 1'b0;
      bus.Done       <= 1'b0;
`ifdef MEM_TIMEOUT_EN
      bus.Err        <= 1'b0;
      waitCnt        <= '0;
`endif
    end else begin
      bus.Done    <= 1'b0;
      bus.RDataOE <= 1'b0;
      unique case (state)
        IDLE: if (bus.Req) begin
          state          <= ADDR;
          isWrite        <= bus.ReqWrite;
          bus.MemAddr    <= bus.AddrIn;
          bus.MemDataOut <= bus.WDataIn;
          bus.nME        <= 1'b0;
          bus.RnW        <= ~bus.ReqWrite;
          bus.Busy       <= 1'b1;
          bus.nOE        <= 1'b1;
          bus.MemDataOE  <= 1'b0;
`ifdef MEM_TIMEOUT_EN
          bus.Err        <= 1'b0;
`endif
        end
        ADDR: begin
          state         <= ACCESS;
          bus.nOE       <= isWrite;
          bus.MemDataOE <= isWrite;
`ifdef MEM_TIMEOUT_EN
          waitCnt       <= '0;
`endif
        end
        ACCESS: begin
          if (accessEnd) begin
            state         <= DONE;
            bus.Done      <= 1'b1;
            bus.nME       <= 1'b1;
            bus.nOE       <= 1'b1;
            bus.MemDataOE <= 1'b0;
            bus.RnW       <= 1'b1;
            if (bus.nWait && !isWrite) begin
              bus.RData   <= bus.MemDataIn;
              bus.RDataOE <= 1'b1;
            end
`ifdef MEM_TIMEOUT_EN
            if (timeoutHit) bus.Err <= 1'b1;
`endif
          end
`ifdef MEM_TIMEOUT_EN
          else waitCnt <= waitCnt + 8'd1;
`endif
        end
        DONE: begin
          state    <= IDLE;
          bus.Busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
